// File: rtl/axi4_slave_mem.sv
// AXI4 slave memory: independent write and read burst FSMs over one word array.
// Out-of-range beats are dropped on write and read back as zero with SLVERR.
module axi4_slave_mem #(
  parameter int ADDR_WIDTH = 24,
  parameter int LEN_WIDTH  = 8,
  parameter int DEPTH      = 1024
) (
  input  logic                  s_axi_aclk,
  input  logic                  s_axi_areset,
  input  logic [ADDR_WIDTH-1:0] s_axi_awaddr,
  input  logic [LEN_WIDTH-1:0]  s_axi_awlen,
  input  logic [1:0]            s_axi_awburst,
  input  logic                  s_axi_awvalid,
  output logic                  s_axi_awready,
  input  logic [31:0]           s_axi_wdata,
  input  logic [3:0]            s_axi_wstrb,
  input  logic                  s_axi_wlast,
  input  logic                  s_axi_wvalid,
  output logic                  s_axi_wready,
  output logic [1:0]            s_axi_bresp,
  output logic                  s_axi_bvalid,
  input  logic                  s_axi_bready,
  input  logic [ADDR_WIDTH-1:0] s_axi_araddr,
  input  logic [LEN_WIDTH-1:0]  s_axi_arlen,
  input  logic [1:0]            s_axi_arburst,
  input  logic                  s_axi_arvalid,
  output logic                  s_axi_arready,
  output logic [31:0]           s_axi_rdata,
  output logic [1:0]            s_axi_rresp,
  output logic                  s_axi_rlast,
  output logic                  s_axi_rvalid,
  input  logic                  s_axi_rready
);

  localparam int IW = $clog2(DEPTH);
  localparam int XW = ADDR_WIDTH - 2;
  localparam logic [XW-1:0] WORDS = XW'(DEPTH);

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wstate_t;
  typedef enum logic {R_IDLE, R_DATA} rstate_t;

  logic [31:0] mem [DEPTH];

  // Byte offsets never select anything; addresses are tracked as word indices.
  logic addr_lsb_unused;
  assign addr_lsb_unused = ^{s_axi_awaddr[1:0], s_axi_araddr[1:0]};

  wstate_t              w_state;
  logic [XW-1:0]        w_addr;
  logic [LEN_WIDTH-1:0] w_len;
  logic [LEN_WIDTH-1:0] w_cnt;
  logic                 w_fixed;
  logic                 w_err;
  logic                 w_in;
  logic                 w_fire;
  logic                 w_last;
  logic                 w_bad;

  assign w_in   = w_addr < WORDS;
  assign w_fire = s_axi_wvalid && s_axi_wready;
  assign w_last = w_cnt == w_len;
  assign w_bad  = !w_in || (s_axi_wlast != w_last);

  always_ff @(posedge s_axi_aclk) begin
    if (s_axi_areset) begin
      w_state       <= W_IDLE;
      s_axi_awready <= 1'b0;
      s_axi_wready  <= 1'b0;
      s_axi_bvalid  <= 1'b0;
      s_axi_bresp   <= 2'b00;
      w_addr        <= '0;
      w_len         <= '0;
      w_cnt         <= '0;
      w_fixed       <= 1'b0;
      w_err         <= 1'b0;
    end else begin
      unique case (w_state)
        W_IDLE: begin
          if (s_axi_awvalid && s_axi_awready) begin
            w_addr        <= s_axi_awaddr[ADDR_WIDTH-1:2];
            w_len         <= s_axi_awlen;
            w_fixed       <= s_axi_awburst == 2'b00;
            w_cnt         <= '0;
            w_err         <= 1'b0;
            s_axi_awready <= 1'b0;
            s_axi_wready  <= 1'b1;
            w_state       <= W_DATA;
          end else begin
            s_axi_awready <= 1'b1;
          end
        end
        W_DATA: begin
          if (w_fire) begin
            if (!w_fixed) w_addr <= w_addr + XW'(1);
            w_cnt <= w_cnt + LEN_WIDTH'(1);
            w_err <= w_err | w_bad;
            // The beat counter, not wlast, closes the burst.
            if (w_last) begin
              s_axi_wready <= 1'b0;
              s_axi_bvalid <= 1'b1;
              s_axi_bresp  <= (w_err || w_bad) ? 2'b10 : 2'b00;
              w_state      <= W_RESP;
            end
          end
        end
        W_RESP: begin
          if (s_axi_bready) begin
            s_axi_bvalid  <= 1'b0;
            s_axi_awready <= 1'b1;
            w_state       <= W_IDLE;
          end
        end
        default: w_state <= W_IDLE;
      endcase
    end
  end

  always_ff @(posedge s_axi_aclk) begin
    if (!s_axi_areset && w_fire && w_in) begin
      for (int i = 0; i < 4; i++) begin
        if (s_axi_wstrb[i]) mem[w_addr[IW-1:0]][8*i +: 8] <= s_axi_wdata[8*i +: 8];
      end
    end
  end

  rstate_t              r_state;
  logic [XW-1:0]        r_addr;
  logic [LEN_WIDTH-1:0] r_len;
  logic [LEN_WIDTH-1:0] r_cnt;
  logic                 r_fixed;
  logic [XW-1:0]        r_nidx;
  logic [XW-1:0]        r_fidx;
  logic                 r_fin;
  logic [31:0]          r_word;

  // Fetch address: the AR start word when idle, else the following beat.
  assign r_nidx = r_fixed ? r_addr : r_addr + XW'(1);
  assign r_fidx = (r_state == R_IDLE) ? s_axi_araddr[ADDR_WIDTH-1:2] : r_nidx;
  assign r_fin  = r_fidx < WORDS;
  assign r_word = r_fin ? mem[r_fidx[IW-1:0]] : 32'h0;

  always_ff @(posedge s_axi_aclk) begin
    if (s_axi_areset) begin
      r_state       <= R_IDLE;
      s_axi_arready <= 1'b0;
      s_axi_rvalid  <= 1'b0;
      s_axi_rlast   <= 1'b0;
      s_axi_rresp   <= 2'b00;
      s_axi_rdata   <= 32'h0;
      r_addr        <= '0;
      r_len         <= '0;
      r_cnt         <= '0;
      r_fixed       <= 1'b0;
    end else begin
      unique case (r_state)
        R_IDLE: begin
          if (s_axi_arvalid && s_axi_arready) begin
            r_addr        <= s_axi_araddr[ADDR_WIDTH-1:2];
            r_len         <= s_axi_arlen;
            r_fixed       <= s_axi_arburst == 2'b00;
            r_cnt         <= '0;
            s_axi_arready <= 1'b0;
            s_axi_rvalid  <= 1'b1;
            s_axi_rdata   <= r_word;
            s_axi_rresp   <= r_fin ? 2'b00 : 2'b10;
            s_axi_rlast   <= s_axi_arlen == '0;
            r_state       <= R_DATA;
          end else begin
            s_axi_arready <= 1'b1;
          end
        end
        R_DATA: begin
          if (s_axi_rready) begin
            if (s_axi_rlast) begin
              s_axi_rvalid  <= 1'b0;
              s_axi_rlast   <= 1'b0;
              s_axi_arready <= 1'b1;
              r_state       <= R_IDLE;
            end else begin
              r_addr      <= r_nidx;
              r_cnt       <= r_cnt + LEN_WIDTH'(1);
              s_axi_rdata <= r_word;
              s_axi_rresp <= r_fin ? 2'b00 : 2'b10;
              s_axi_rlast <= (r_cnt + LEN_WIDTH'(1)) == r_len;
            end
          end
        end
        default: r_state <= R_IDLE;
      endcase
    end
  end

endmodule
